// File: rtl/alarm_tone_gen_if.sv
// Control/status bundle of the alarm tone generator.
// The master drives requests; the slave (the generator) drives the tone and status.
interface alarm_tone_gen_if;
    logic       ena;
    logic [2:0] alarm_in;
    logic       ack;
    logic       tone_out;
    logic [1:0] active_ch;
    logic       busy;
    logic [2:0] latched;

    modport master (
        output ena, alarm_in, ack,
        input  tone_out, active_ch, busy, latched
    );

    modport slave (
        input  ena, alarm_in, ack,
        output tone_out, active_ch, busy, latched
    );
endinterface

// File: rtl/alarm_tone_gen.sv
// Three-channel priority alarm tone generator: a beeping square wave with on/off cadence.
// The tone pitch follows the highest-priority alarm, and a sticky per-channel latch is cleared by ack.
module alarm_tone_gen #(
    parameter int unsigned DIV1    = 4,
    parameter int unsigned DIV2    = 6,
    parameter int unsigned DIV3    = 8,
    parameter int unsigned CAD_ON  = 16,
    parameter int unsigned CAD_OFF = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alarm_tone_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, TONE_ON, TONE_OFF} state_t;

    localparam logic [7:0] CAD_ON_LAST  = 8'(CAD_ON - 1);
    localparam logic [7:0] CAD_OFF_LAST = 8'(CAD_OFF - 1);

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] cad_cnt_q, cad_cnt_d;
    logic       tone_q, tone_d;
    logic [1:0] active_q, active_d;
    logic       busy_q, busy_d;
    logic [2:0] latched_q, latched_d;
    logic [1:0] hi_ch;

    function automatic logic [1:0] highest(input logic [2:0] req);
        if (req[2])      return 2'd3;
        else if (req[1]) return 2'd2;
        else if (req[0]) return 2'd1;
        else             return 2'd0;
    endfunction

    function automatic logic [7:0] div_last(input logic [1:0] ch);
        case (ch)
            2'd2:    return 8'(DIV2 - 1);
            2'd3:    return 8'(DIV3 - 1);
            default: return 8'(DIV1 - 1);
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        cad_cnt_d = cad_cnt_q;
        tone_d    = tone_q;
        active_d  = active_q;
        latched_d = latched_q;
        hi_ch     = highest(bus.alarm_in);

        if (bus.ena) begin
            // a channel asserting on the ack edge stays latched
            latched_d = (bus.ack ? 3'b000 : latched_q) | bus.alarm_in;
            case (state_q)
                IDLE: begin
                    if (hi_ch != 2'd0) begin
                        state_d   = TONE_ON;
                        active_d  = hi_ch;
                        div_cnt_d = 8'd0;
                        cad_cnt_d = 8'd0;
                        tone_d    = 1'b0;
                    end
                end
                TONE_ON: begin
                    if (hi_ch > active_q) begin
                        active_d  = hi_ch;
                        div_cnt_d = 8'd0;
                        cad_cnt_d = 8'd0;
                        tone_d    = 1'b0;
                    end else if (cad_cnt_q == CAD_ON_LAST) begin
                        state_d   = TONE_OFF;
                        div_cnt_d = 8'd0;
                        cad_cnt_d = 8'd0;
                        tone_d    = 1'b0;
                    end else begin
                        cad_cnt_d = cad_cnt_q + 8'd1;
                        if (div_cnt_q == div_last(active_q)) begin
                            tone_d    = ~tone_q;
                            div_cnt_d = 8'd0;
                        end else begin
                            div_cnt_d = div_cnt_q + 8'd1;
                        end
                    end
                end
                TONE_OFF: begin
                    if (cad_cnt_q == CAD_OFF_LAST) begin
                        div_cnt_d = 8'd0;
                        cad_cnt_d = 8'd0;
                        if (hi_ch != 2'd0) begin
                            state_d  = TONE_ON;
                            active_d = hi_ch;
                        end else begin
                            state_d  = IDLE;
                            active_d = 2'd0;
                        end
                    end else begin
                        cad_cnt_d = cad_cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= 8'd0;
            cad_cnt_q <= 8'd0;
            tone_q    <= 1'b0;
            active_q  <= 2'd0;
            busy_q    <= 1'b0;
            latched_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            cad_cnt_q <= cad_cnt_d;
            tone_q    <= tone_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            latched_q <= latched_d;
        end
    end

    assign bus.tone_out  = tone_q;
    assign bus.active_ch = active_q;
    assign bus.busy      = busy_q;
    assign bus.latched   = latched_q;
endmodule

// File: tb/tb_alarm_tone_gen.sv
// Randomised bench for alarm_tone_gen against a phase/time-based reference model.
// The model tracks mode, channel and cycles-into-phase; the tone is derived arithmetically.
module tb_alarm_tone_gen;
    localparam int DIV1 = 4, DIV2 = 6, DIV3 = 8, CAD_ON = 16, CAD_OFF = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // model: mode 0 = silent, 1 = beeping, 2 = pause between beeps
    int         m_mode = 0;
    int         m_ch   = 0;
    int         m_t    = 0;
    logic [2:0] m_lat  = 3'b000;

    alarm_tone_gen_if bus ();

    alarm_tone_gen #(
        .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .CAD_ON(CAD_ON), .CAD_OFF(CAD_OFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_tone();
        int div;
        div = (m_ch == 3) ? DIV3 : (m_ch == 2) ? DIV2 : DIV1;
        return (m_mode == 1) ? ((m_t / div) % 2) : 0;
    endfunction

    function automatic void model_step(input logic [2:0] al, input logic ack, input logic en);
        int hi;
        if (!en) return;
        hi = al[2] ? 3 : al[1] ? 2 : al[0] ? 1 : 0;
        m_lat = (ack ? 3'b000 : m_lat) | al;
        case (m_mode)
            0: if (hi != 0) begin m_mode = 1; m_ch = hi; m_t = 0; end
            1: begin
                if (hi > m_ch) begin
                    m_ch = hi; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == CAD_ON) begin m_mode = 2; m_t = 0; end
                end
            end
            default: begin
                m_t++;
                if (m_t == CAD_OFF) begin
                    m_t = 0;
                    if (hi != 0) begin m_mode = 1; m_ch = hi; end
                    else begin m_mode = 0; m_ch = 0; end
                end
            end
        endcase
    endfunction

    task automatic step(input logic [2:0] al, input logic ack, input logic en);
        @(negedge clk);
        bus.alarm_in = al;
        bus.ack      = ack;
        bus.ena      = en;
        @(posedge clk);
        #1;
        model_step(al, ack, en);
        chk("tone_out",  int'(bus.tone_out),  exp_tone());
        chk("active_ch", int'(bus.active_ch), m_ch);
        chk("busy",      int'(bus.busy),      (m_mode != 0) ? 1 : 0);
        chk("latched",   int'(bus.latched),   int'(m_lat));
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tone",    int'(bus.tone_out),  0);
        chk("rst_busy",    int'(bus.busy),      0);
        chk("rst_latched", int'(bus.latched),   0);
        chk("rst_active",  int'(bus.active_ch), 0);
        m_mode = 0; m_ch = 0; m_t = 0; m_lat = 3'b000;
        bus.ena = 1'b0;
        bus.alarm_in = 3'b000;
        bus.ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] al;
        bus.ena = 1'b0;
        bus.alarm_in = 3'b000;
        bus.ack = 1'b0;
        #12;
        chk("reset_tone",    int'(bus.tone_out),  0);
        chk("reset_busy",    int'(bus.busy),      0);
        chk("reset_active",  int'(bus.active_ch), 0);
        chk("reset_latched", int'(bus.latched),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch1 held through two full beep cycles
        repeat (70) step(3'b001, 1'b0, 1'b1);
        // ch3 preempts ch1 partway into an on-phase
        for (int i = 0; i < 40 && !(m_mode == 1 && m_t == 5); i++) step(3'b001, 1'b0, 1'b1);
        chk("pre_preempt_ch", int'(bus.active_ch), 1);
        repeat (20) step(3'b101, 1'b0, 1'b1);
        // ch3 request arriving during the pause waits for the pause to end
        repeat (40) step(3'b000, 1'b0, 1'b1);
        repeat (3)  step(3'b001, 1'b0, 1'b1);
        for (int i = 0; i < 40 && m_mode != 2; i++) step(3'b001, 1'b0, 1'b1);
        repeat (20) step(3'b100, 1'b0, 1'b1);
        // one-cycle ch2 pulse from silence, ack clearing old latches
        repeat (40) step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b1, 1'b1);
        step(3'b010, 1'b0, 1'b1);
        repeat (40) step(3'b000, 1'b0, 1'b1);
        // ack coinciding with a new request, then a 10-cycle freeze mid-beep
        step(3'b011, 1'b0, 1'b1);
        step(3'b001, 1'b1, 1'b1);
        repeat (6)  step(3'b001, 1'b0, 1'b1);
        repeat (10) step(3'b111, 1'b1, 1'b0);
        repeat (12) step(3'b001, 1'b0, 1'b1);
        // asynchronous reset while the tone is high
        for (int i = 0; i < 100 && !(m_mode == 1 && exp_tone() == 1); i++) step(3'b001, 1'b0, 1'b1);
        chk("pre_rst_tone", int'(bus.tone_out), 1);
        async_reset_check();
        repeat (5) step(3'b010, 1'b0, 1'b1);

        al = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                al = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            step(al, ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) != 0));
            if (i == 1500) async_reset_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alarm_tone_gen.md
ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

Interface
REQ-001 Parameter DIV1, default 4: tone half-period in clk cycles for channel 1 (legal range 1..255).
REQ-002 Parameter DIV2, default 6: tone half-period for channel 2 (legal range 1..255).
REQ-003 Parameter DIV3, default 8: tone half-period for channel 3 (legal range 1..255).
REQ-004 Parameter CAD_ON, default 16: beep on-phase length in cycles (legal range 1..255).
REQ-005 Parameter CAD_OFF, default 16: beep off-phase length in cycles (legal range 1..255).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 ena  in  1  clock enable; low = every register holds its value.
REQ-009 alarm_in  in  3  level alarm requests from the sensor/buzzer stage; bit0 = ch1, bit1 = ch2, bit2 = ch3.
REQ-010 ack  in  1  single-cycle pulse that clears latched.
REQ-011 tone_out  out  1  square-wave audio drive.
REQ-012 active_ch  out  2  channel currently sounding; 0 = none, 1..3 = channel.
REQ-013 busy  out  1  high in TONE_ON and TONE_OFF.
REQ-014 latched  out  3  sticky record of each alarm channel ever asserted since the last ack.

Function
REQ-015 Priority SHALL be fixed: ch3 > ch2 > ch1; "highest" means the highest-numbered asserted bit of alarm_in.
REQ-016 FSM states SHALL be IDLE, TONE_ON, TONE_OFF; all transitions SHALL occur only on edges where ena=1.
REQ-017 IDLE: tone_out=0, active_ch=0, busy=0; if alarm_in!=0, go to TONE_ON next edge with active_ch=highest, div_cnt=0, cad_cnt=0, tone_out=0.
REQ-018 TONE_ON divider: each cycle, if div_cnt==DIVn-1, toggle tone_out and clear div_cnt; else increment div_cnt (DIVn per active_ch); first tone_out rise is DIVn cycles after entry.
REQ-019 TONE_ON cadence: cad_cnt increments each cycle; when cad_cnt==CAD_ON-1, go to TONE_OFF, tone_out<=0, cad_cnt<=0, div_cnt<=0.
REQ-020 TONE_ON preemption: if a channel of higher priority than active_ch asserts, on the next edge active_ch<=that channel, div_cnt<=0, cad_cnt<=0, tone_out<=0, remaining in TONE_ON.
REQ-021 Dropping the active alarm_in bit during TONE_ON SHALL NOT shorten the on-phase (minimum beep = CAD_ON cycles).
REQ-022 TONE_OFF: tone_out=0, active_ch holds; cad_cnt counts to CAD_OFF-1, then re-evaluate alarm_in: nonzero -> TONE_ON with active_ch=highest and counters cleared; zero -> IDLE, active_ch<=0.
REQ-023 Alarms asserting during TONE_OFF (including higher priority) SHALL NOT preempt; they are taken at the end of the off-phase.
REQ-024 latched[i] SHALL be set on every ena=1 edge where alarm_in[i]=1, and cleared on an ena=1 edge where ack=1; set wins when both apply to the same bit.
REQ-025 Counters SHALL be 8 bits and never wrap in legal operation; illegal parameter value 0 is out of scope.
REQ-026 busy SHALL equal (state!=IDLE), registered alongside the state.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, tone_out=0, active_ch=0, busy=0, latched=0, div_cnt=0, cad_cnt=0, independent of clk and ena.
REQ-028 Reset asserted mid-beep SHALL silence tone_out without waiting for a clock edge; after release, the first ena=1 edge with alarm_in!=0 starts a fresh on-phase.

Verification
REQ-029 Defaults, alarm_in=3'b001 held -> busy=1, active_ch=1 after 1 edge; tone_out period 8 cycles for 16 cycles, then 16 cycles low, then repeats.
REQ-030 ch1 sounding, alarm_in=3'b101 at on-phase cycle 5 -> next edge active_ch=3, counters cleared, tone_out period 16, on-phase full 16 cycles.
REQ-031 alarm_in=3'b010 pulsed 1 cycle -> exactly one 16-cycle on-phase (period 12), 16-cycle off-phase, then IDLE, active_ch=0, latched=3'b010.
REQ-032 alarm_in=3'b100 asserted during TONE_OFF with ch1 active -> no change until off-phase end, then active_ch=3.
REQ-033 latched=3'b011, ack=1 with alarm_in=3'b001 same cycle -> latched=3'b001; ena=0 for 10 cycles mid-beep -> tone_out, counters, and state frozen, resuming exactly where they stopped.
REQ-034 rst_n driven low between clk edges during TONE_ON -> tone_out=0, busy=0, latched=0 before the next edge.
